// File: rtl/rf_ctrl_pkg.sv
// Shared constants and FSM encoding for the register-file write scheduler.
// Widths here are the defaults; the top re-derives sizes from its own parameters.
package rf_ctrl_pkg;

  localparam int N       = 4;
  localparam int M       = 32;
  localparam int NREG    = 2 ** N;
  localparam int R15_IDX = NREG - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR0  = 2'd1,
    WR1  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational grant, registered priority pointer.
// The pointer always moves to the requester that lost (or was not served) by the last grant.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic hold,
  output logic grant0,
  output logic grant1
);

  logic prio_q;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && !hold) begin
      if (valid0 && (!valid1 || !prio_q)) grant0 = 1'b1;
      else if (valid1)                    grant1 = 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so all flops sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      prio_q <= 1'b0;
    else if (grant0) prio_q <= 1'b1;
    else if (grant1) prio_q <= 1'b0;
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Arbitrates two write requesters onto one register-file write port and keeps a busy
// scoreboard of reserved destination registers; the top register (PC) is never reserved.
module rf_write_scheduler #(
  parameter int N = rf_ctrl_pkg::N,
  parameter int M = rf_ctrl_pkg::M
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [N-1:0]      req0_addr,
  input  logic [M-1:0]      req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [N-1:0]      req1_addr,
  input  logic [M-1:0]      req1_data,
  output logic              req1_ready,
  input  logic              hold,
  input  logic              rsv_valid,
  input  logic [N-1:0]      rsv_addr,
  input  logic [N-1:0]      q_addr1,
  input  logic [N-1:0]      q_addr2,
  output logic              q_busy1,
  output logic              q_busy2,
  output logic [2**N-1:0]   busy_vec,
  output logic              WE3,
  output logic [N-1:0]      A3,
  output logic [M-1:0]      WD3
);

  localparam int NREG   = 2 ** N;
  localparam int PC_IDX = NREG - 1;

  logic                grant0, grant1, grant_any;
  logic [N-1:0]        gnt_addr;
  logic [NREG-1:0]     busy_q, busy_d;
  logic [N-1:0]        a3_q;
  logic [M-1:0]        wd3_q;
  rf_ctrl_pkg::state_e state_q;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (reset),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .hold   (hold),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign grant_any  = grant0 | grant1;
  assign gnt_addr   = grant1 ? req1_addr : req0_addr;

  // Clear on write, then set on reservation so a same-cycle reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (grant_any) busy_d[gnt_addr] = 1'b0;
    if (rsv_valid) busy_d[rsv_addr] = 1'b1;
    busy_d[PC_IDX] = 1'b0;
  end

  // NOTE: the scoreboard is a plain flop vector, so it is cleared by reset like any other state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= rf_ctrl_pkg::IDLE;
      a3_q    <= '0;
      wd3_q   <= '0;
    end else if (grant0) begin
      state_q <= rf_ctrl_pkg::WR0;
      a3_q    <= req0_addr;
      wd3_q   <= req0_data;
    end else if (grant1) begin
      state_q <= rf_ctrl_pkg::WR1;
      a3_q    <= req1_addr;
      wd3_q   <= req1_data;
    end else begin
      state_q <= rf_ctrl_pkg::IDLE;
    end
  end

  assign WE3      = (state_q != rf_ctrl_pkg::IDLE);
  assign A3       = a3_q;
  assign WD3      = wd3_q;
  assign busy_vec = busy_q;
  assign q_busy1  = busy_q[q_addr1];
  assign q_busy2  = busy_q[q_addr2];

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler: inputs change 1 time unit after a rising edge,
// combinational outputs are checked before the next edge, registered ones just after it.
module tb_rf_write_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_addr, req1_addr, rsv_addr, q_addr1, q_addr2, A3;
  logic [31:0] req0_data, req1_data, WD3;
  logic        hold, rsv_valid, q_busy1, q_busy2, WE3;
  logic [15:0] busy_vec;

  int vectors = 0;
  int miscompares = 0;

  rf_write_scheduler #(.N(4), .M(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .hold(hold), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .busy_vec(busy_vec), .WE3(WE3), .A3(A3), .WD3(WD3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; hold = 1'b0; rsv_valid = 1'b0; rsv_addr = '0;
    req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 32'hDEADBEEF;
    req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 32'h0;
    q_addr1 = 4'd0; q_addr2 = 4'd0;

    // Reset state: requests pending but nothing granted or issued.
    tick(); tick();
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_ready1", req1_ready, 1'b0);
    check("rst_we3", WE3, 1'b0);
    check("rst_a3", A3, 4'd0);
    check("rst_wd3", WD3, 32'd0);
    check("rst_busy", busy_vec, 16'h0000);
    req1_valid = 1'b0;
    reset = 1'b1;

    // Single request: grant at t, write at t+1, idle at t+2.
    #1;
    check("single_ready0", req0_ready, 1'b1);
    check("single_ready1", req1_ready, 1'b0);
    tick(); req0_valid = 1'b0;
    check("single_we3", WE3, 1'b1);
    check("single_a3", A3, 4'd3);
    check("single_wd3", WD3, 32'hDEADBEEF);
    tick();
    check("single_we3_off", WE3, 1'b0);
    check("single_a3_keep", A3, 4'd3);

    // Contention right after reset: grants alternate 0,1,0,1 with WE3 high back to back.
    reset = 1'b0; #1; reset = 1'b1;
    req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 32'h1111_1111;
    req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 32'h2222_2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_ready0", req0_ready, (i % 2 == 0));
      check("cont_ready1", req1_ready, (i % 2 == 1));
      tick();
      check("cont_we3", WE3, 1'b1);
      check("cont_a3", A3, (i % 2 == 0) ? 4'd1 : 4'd2);
      check("cont_wd3", WD3, (i % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("cont_we3_off", WE3, 1'b0);

    // Scoreboard: reserve 5, query sees it only after the edge, write to 5 clears it.
    rsv_valid = 1'b1; rsv_addr = 4'd5; q_addr1 = 4'd5;
    #1;
    check("sb_no_bypass", q_busy1, 1'b0);
    tick(); rsv_valid = 1'b0;
    check("sb_busy5", busy_vec, 16'h0020);
    check("sb_qbusy1", q_busy1, 1'b1);
    req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 32'h5555_5555;
    #1;
    check("sb_ready0", req0_ready, 1'b1);
    tick(); req0_valid = 1'b0;
    check("sb_clear5", busy_vec, 16'h0000);
    check("sb_qbusy1_clr", q_busy1, 1'b0);
    check("sb_a3", A3, 4'd5);

    // Same-cycle reserve and write of 7: set wins.
    rsv_valid = 1'b1; rsv_addr = 4'd7;
    req1_valid = 1'b1; req1_addr = 4'd7; req1_data = 32'h7777_7777;
    #1;
    check("coll_ready1", req1_ready, 1'b1);
    tick(); req1_valid = 1'b0;
    check("coll_busy7", busy_vec, 16'h0080);
    check("coll_we3", WE3, 1'b1);
    check("coll_a3", A3, 4'd7);

    // Reserving 7 again is a no-op; reserving R15 is ignored but a write to R15 is issued.
    rsv_addr = 4'd7;
    tick();
    check("rsv_again", busy_vec, 16'h0080);
    rsv_addr = 4'd15; q_addr2 = 4'd15;
    tick(); rsv_valid = 1'b0;
    check("rsv15_vec", busy_vec, 16'h0080);
    check("rsv15_q2", q_busy2, 1'b0);
    req0_valid = 1'b1; req0_addr = 4'd15; req0_data = 32'h0000_00FF;
    tick(); req0_valid = 1'b0;
    check("r15_we3", WE3, 1'b1);
    check("r15_a3", A3, 4'd15);
    check("r15_wd3", WD3, 32'h0000_00FF);

    // Hold with both valid: no grants, WE3 drops; prio (now 1) survives the hold.
    hold = 1'b1;
    req0_valid = 1'b1; req0_addr = 4'd8; req0_data = 32'h8888_8888;
    req1_valid = 1'b1; req1_addr = 4'd9; req1_data = 32'h9999_9999;
    #1;
    check("hold_ready0", req0_ready, 1'b0);
    check("hold_ready1", req1_ready, 1'b0);
    tick();
    check("hold_we3_a", WE3, 1'b0);
    tick();
    check("hold_we3_b", WE3, 1'b0);
    hold = 1'b0;
    #1;
    check("resume_ready1", req1_ready, 1'b1);
    check("resume_ready0", req0_ready, 1'b0);
    tick(); req1_valid = 1'b0;
    check("resume_a3", A3, 4'd9);
    #1;
    check("resume_ready0b", req0_ready, 1'b1);
    tick(); req0_valid = 1'b0; hold = 1'b1;
    check("hold_late_we3", WE3, 1'b1);
    check("hold_late_a3", A3, 4'd8);
    tick(); hold = 1'b0;
    check("hold_late_off", WE3, 1'b0);

    // Reset in the cycle after a grant kills the pending write and the scoreboard.
    rsv_valid = 1'b1; rsv_addr = 4'd4;
    tick(); rsv_valid = 1'b0;
    check("mid_busy4", busy_vec, 16'h0090);
    req0_valid = 1'b1; req0_addr = 4'd6; req0_data = 32'h6666_6666;
    tick();
    check("mid_we3_pre", WE3, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_we3", WE3, 1'b0);
    check("mid_busy", busy_vec, 16'h0000);
    check("mid_a3", A3, 4'd0);
    check("mid_ready0", req0_ready, 1'b0);
    req0_valid = 1'b0;
    tick(); reset = 1'b1;
    tick();
    check("post_we3_a", WE3, 1'b0);
    tick();
    check("post_we3_b", WE3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
